// File: rtl/adc_meter_pkg.sv
// Shared encodings for the ADC measurement front end.
package adc_meter_pkg;

  // Conditioning modes selected by the mode input
  localparam logic [1:0] MODE_LIVE = 2'd0;
  localparam logic [1:0] MODE_AVG  = 2'd1;
  localparam logic [1:0] MODE_MAX  = 2'd2;
  localparam logic [1:0] MODE_MIN  = 2'd3;

  // Conversion handshake states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PROC = 2'd2
  } state_t;

  // Bits reserved for the full-scale millivolt coefficient (up to 4095 mV)
  localparam int MV_COEF_W = 12;

  // Width of sample x full-scale product
  function automatic int prod_w(input int data_w);
    return data_w + MV_COEF_W;
  endfunction

endpackage

// File: rtl/adc_meter_scale.sv
// Registered conversion of a conditioned code into millivolts.
module adc_meter_scale
  import adc_meter_pkg::*;
#(
  parameter int DATA_W        = 10,
  parameter int FULL_SCALE_MV = 3300
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] value_p1,
  input  logic              vld_p1,
  output logic [15:0]       result_mv,
  output logic              result_valid
);

  localparam int PROD_W = prod_w(DATA_W);

  logic [15:0] mv_p2;
  logic        vld_p2;

  // Code to millivolts, truncating the fractional part
  function automatic logic [15:0] to_mv(input logic [DATA_W-1:0] v);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(v) * PROD_W'(FULL_SCALE_MV);
    return 16'(prod >> DATA_W);
  endfunction

  // p1 -> p2: strobe follows the emit request by one cycle
  always_ff @(posedge sysclk) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1;
  end

  // p1 -> p2: result only changes on an emitted value, otherwise holds
  always_ff @(posedge sysclk) begin
    if (reset)       mv_p2 <= '0;
    else if (vld_p1) mv_p2 <= to_mv(value_p1);
  end

  assign result_mv    = mv_p2;
  assign result_valid = vld_p2;

endmodule

// File: rtl/adc_meter.sv
// ADC front end: periodic conversion start, start/valid handshake with
// timeout, per-mode sample conditioning and millivolt scaling.
module adc_meter
  import adc_meter_pkg::*;
#(
  parameter int DATA_W        = 10,
  parameter int N_DIV         = 999,
  parameter int AVG_LOG2      = 4,
  parameter int FULL_SCALE_MV = 3300,
  parameter int TIMEOUT       = 2047
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              clear,
  output logic              adc_start,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [15:0]       result_mv,
  output logic              result_valid,
  output logic              busy,
  output logic              overrun,
  output logic              adc_err
);

  localparam int TICK_W = (N_DIV > 0) ? $clog2(N_DIV + 1) : 1;
  localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(2 ** AVG_LOG2);
  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  state_t              state, state_nx;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                tmo_exp;
  logic                start_nx, adc_start_q;
  logic [DATA_W-1:0]   sample_p0;
  logic [1:0]          mode_q;
  logic                mode_chg;
  logic [ACC_W-1:0]    acc, acc_base, acc_sum;
  logic [CNT_W-1:0]    cnt, cnt_base, cnt_inc;
  logic [DATA_W-1:0]   max_r, min_r, max_base, min_base, max_nx, min_nx;
  logic [DATA_W-1:0]   value_p1;
  logic                vld_p1;
  logic                overrun_q, adc_err_q;

  assign tick     = enable && (tick_cnt == TICK_W'(N_DIV));
  assign tmo_exp  = (state == ST_WAIT) && !adc_valid && (tmo_cnt == '0);
  assign mode_chg = (mode != mode_q);

  // Free-running divider; frozen while disabled
  always_ff @(posedge sysclk) begin
    if (reset)       tick_cnt <= '0;
    else if (enable) tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
  end

  // FSM state register and registered conversion request
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      adc_start_q <= 1'b0;
    end else begin
      state       <= state_nx;
      adc_start_q <= start_nx;
    end
  end

  // FSM next state: valid takes priority over an expiring timeout
  always_comb begin
    state_nx = state;
    start_nx = 1'b0;
    case (state)
      ST_IDLE: if (tick) begin
        start_nx = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (adc_valid)          state_nx = ST_PROC;
        else if (tmo_cnt == '0) state_nx = ST_IDLE;
      end
      ST_PROC: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Timeout counter: loaded with the start request, counts down in WAIT
  always_ff @(posedge sysclk) begin
    if (reset)                                  tmo_cnt <= '0;
    else if (start_nx)                          tmo_cnt <= TMO_W'(TIMEOUT);
    else if (state == ST_WAIT && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_W'(1);
  end

  // p0: capture the returned sample
  always_ff @(posedge sysclk) begin
    if (state == ST_WAIT && adc_valid) sample_p0 <= adc_data;
  end

  // Previous mode, used to detect a mode switch
  always_ff @(posedge sysclk) begin
    if (reset) mode_q <= MODE_LIVE;
    else       mode_q <= mode;
  end

  // A mode switch landing on the PROC cycle starts the new mode from scratch
  assign acc_base = mode_chg ? '0 : acc;
  assign cnt_base = mode_chg ? '0 : cnt;
  assign max_base = mode_chg ? '0 : max_r;
  assign min_base = mode_chg ? ALL_ONES : min_r;
  assign acc_sum  = acc_base + ACC_W'(sample_p0);
  assign cnt_inc  = cnt_base + CNT_W'(1);
  assign max_nx   = (sample_p0 > max_base) ? sample_p0 : max_base;
  assign min_nx   = (sample_p0 < min_base) ? sample_p0 : min_base;

  // p0 -> p1: per-mode value and emit decision; clear discards the sample
  always_comb begin
    value_p1 = sample_p0;
    vld_p1   = 1'b0;
    if (state == ST_PROC && !clear) begin
      case (mode)
        MODE_LIVE: vld_p1 = 1'b1;
        MODE_AVG: if (cnt_inc == CNT_FULL) begin
          value_p1 = DATA_W'(acc_sum >> AVG_LOG2);
          vld_p1   = 1'b1;
        end
        MODE_MAX: begin
          value_p1 = max_nx;
          vld_p1   = 1'b1;
        end
        MODE_MIN: begin
          value_p1 = min_nx;
          vld_p1   = 1'b1;
        end
        default: vld_p1 = 1'b0;
      endcase
    end
  end

  // Accumulator and hold registers
  always_ff @(posedge sysclk) begin
    if (reset || clear) begin
      acc   <= '0;
      cnt   <= '0;
      max_r <= '0;
      min_r <= ALL_ONES;
    end else if (state == ST_PROC) begin
      acc   <= acc_base;
      cnt   <= cnt_base;
      max_r <= max_base;
      min_r <= min_base;
      case (mode)
        MODE_AVG: begin
          if (cnt_inc == CNT_FULL) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= acc_sum;
            cnt <= cnt_inc;
          end
        end
        MODE_MAX: max_r <= max_nx;
        MODE_MIN: min_r <= min_nx;
        default: ;
      endcase
    end else if (mode_chg) begin
      acc   <= '0;
      cnt   <= '0;
      max_r <= '0;
      min_r <= ALL_ONES;
    end
  end

  // Sticky status flags
  always_ff @(posedge sysclk) begin
    if (reset || clear) begin
      overrun_q <= 1'b0;
      adc_err_q <= 1'b0;
    end else begin
      if (tick && state != ST_IDLE) overrun_q <= 1'b1;
      if (tmo_exp)                  adc_err_q <= 1'b1;
    end
  end

  // p1 -> p2: scaling stage
  adc_meter_scale #(
    .DATA_W        (DATA_W),
    .FULL_SCALE_MV (FULL_SCALE_MV)
  ) u_scale (
    .sysclk       (sysclk),
    .reset        (reset),
    .value_p1     (value_p1),
    .vld_p1       (vld_p1),
    .result_mv    (result_mv),
    .result_valid (result_valid)
  );

  assign adc_start = adc_start_q;
  assign busy      = (state != ST_IDLE);
  assign overrun   = overrun_q;
  assign adc_err   = adc_err_q;

endmodule
